reaction_timer_core: RTL and testbench

Parametrised multi-player reaction-timer controller. After an arm/release of `start`, it waits a pseudo-random delay, lights the test LED, and timestamps each player's first button press in ms-style ticks. It detects false starts and picks a winner. It sits between the debounced button/switch inputs and the seven-segment/LED display logic, replacing the single-player timer FSM.

---
 rtl/reaction_timer_core.sv | 173 +++++++++++++++++
 tb/tb_reaction_timer_core.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - multi-player reaction timer: random delay, per-player timestamps, false starts, winner
module reaction_timer_core #(
    parameter int NUM_PLAYERS = 4,
    parameter int TIME_W      = 16,
    parameter int TICK_DIV    = 100000,
    parameter int MIN_DELAY   = 1000,
    parameter int DELAY_BITS  = 11
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [NUM_PLAYERS-1:0]        btn,
    output logic                          waiting,
    output logic                          led_on,
    output logic                          done,
    output logic                          timeout,
    output logic [NUM_PLAYERS-1:0]        false_start,
    output logic [NUM_PLAYERS-1:0]        resp_valid,
    output logic [NUM_PLAYERS*TIME_W-1:0] resp_time,
    output logic [2:0]                    winner,
    output logic                          winner_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_DELAY,
        S_TEST,
        S_DONE
    } state_t;

    localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DCW = ((TIME_W > 16) ? TIME_W : 16) + 1;
    localparam logic [PW-1:0]          PRESC_MAX   = PW'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0]      ELAPSED_MAX = '1;
    localparam logic [31:0]            DELAY_MASK  = (32'd1 << DELAY_BITS) - 32'd1;
    localparam logic [NUM_PLAYERS-1:0] ALL_P       = '1;

    state_t                        state_q, state_d;
    logic [15:0]                   lfsr_q, lfsr_d;
    logic [NUM_PLAYERS-1:0]        btn_q;
    logic [PW-1:0]                 presc_q, presc_d;
    logic [DCW-1:0]                delay_q, delay_d;
    logic [TIME_W-1:0]             elapsed_q, elapsed_d;
    logic [NUM_PLAYERS-1:0]        fs_q, fs_d;
    logic [NUM_PLAYERS-1:0]        valid_q, valid_d;
    logic [NUM_PLAYERS*TIME_W-1:0] time_q, time_d;
    logic                          timeout_q, timeout_d;

    logic [NUM_PLAYERS-1:0] press;
    logic                   tick;

    assign press = btn & ~btn_q;
    assign tick  = (presc_q == PRESC_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 16'hACE1;
            btn_q     <= '0;
            presc_q   <= '0;
            delay_q   <= '0;
            elapsed_q <= '0;
            fs_q      <= '0;
            valid_q   <= '0;
            time_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            btn_q     <= btn;
            presc_q   <= presc_d;
            delay_q   <= delay_d;
            elapsed_q <= elapsed_d;
            fs_q      <= fs_d;
            valid_q   <= valid_d;
            time_q    <= time_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        presc_d   = tick ? '0 : presc_q + PW'(1);
        delay_d   = delay_q;
        elapsed_d = elapsed_q;
        fs_d      = fs_q;
        valid_d   = valid_q;
        time_d    = time_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM: begin
                fs_d      = '0;
                valid_d   = '0;
                time_d    = '0;
                timeout_d = 1'b0;
                elapsed_d = '0;
                delay_d   = DCW'(MIN_DELAY) + DCW'(lfsr_q & DELAY_MASK[15:0]);
                if (!start) begin
                    state_d = S_DELAY;
                    presc_d = '0;
                end
            end
            S_DELAY: begin
                fs_d = fs_q | press;
                // A full house of false starts ends the round before any tick handling.
                if (fs_d == ALL_P) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    delay_d = delay_q - DCW'(1);
                    if (delay_q == DCW'(1)) begin
                        state_d   = S_TEST;
                        presc_d   = '0;
                        elapsed_d = '0;
                    end
                end
            end
            S_TEST: begin
                if (tick && elapsed_q != ELAPSED_MAX) elapsed_d = elapsed_q + TIME_W'(1);
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    if (press[i] && !fs_q[i] && !valid_q[i]) begin
                        valid_d[i]                   = 1'b1;
                        time_d[i*TIME_W +: TIME_W]   = elapsed_q;
                    end
                end
                if ((valid_d | fs_q) == ALL_P) begin
                    state_d = S_DONE;
                end else if (tick && elapsed_q == ELAPSED_MAX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                if (start) state_d = S_ARM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [2:0]        best_idx;
    logic [TIME_W-1:0] best_time;
    logic              found;

    // Strict less-than keeps the lowest index on equal times.
    always_comb begin
        best_idx  = '0;
        best_time = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (valid_q[i] && (!found || time_q[i*TIME_W +: TIME_W] < best_time)) begin
                found     = 1'b1;
                best_idx  = 3'(i);
                best_time = time_q[i*TIME_W +: TIME_W];
            end
        end
    end

    assign waiting      = (state_q == S_IDLE) || (state_q == S_ARM);
    assign led_on       = (state_q == S_TEST);
    assign done         = (state_q == S_DONE);
    assign timeout      = timeout_q;
    assign false_start  = fs_q;
    assign resp_valid   = valid_q;
    assign resp_time    = time_q;
    assign winner       = done ? best_idx : 3'd0;
    assign winner_valid = done && found;

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - randomized bench for reaction_timer_core against a round-level model
module tb_reaction_timer_core;

    localparam int NP       = 4;
    localparam int TW       = 4;
    localparam int TICK     = 4;
    localparam int MIND     = 3;
    localparam int DLY_CYC  = MIND * TICK;
    localparam int TEST_CYC = (1 << TW) * TICK;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [NP-1:0]    btn = '0;
    logic             waiting, led_on, done, timeout, winner_valid;
    logic [NP-1:0]    false_start, resp_valid;
    logic [NP*TW-1:0] resp_time;
    logic [2:0]       winner;

    logic        start2 = 1'b0;
    logic [1:0]  btn2 = '0;
    logic        waiting2, led_on2, done2, timeout2, wv2;
    logic [1:0]  fs2, rv2;
    logic [15:0] rt2;
    logic [2:0]  winner2;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned edge_cnt;

    reaction_timer_core #(.NUM_PLAYERS(NP), .TIME_W(TW), .TICK_DIV(TICK),
                          .MIN_DELAY(MIND), .DELAY_BITS(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .btn(btn),
        .waiting(waiting), .led_on(led_on), .done(done), .timeout(timeout),
        .false_start(false_start), .resp_valid(resp_valid), .resp_time(resp_time),
        .winner(winner), .winner_valid(winner_valid)
    );

    reaction_timer_core #(.NUM_PLAYERS(2), .TIME_W(8), .TICK_DIV(2),
                          .MIN_DELAY(2), .DELAY_BITS(3)) dut_r (
        .clk(clk), .reset_n(reset_n), .start(start2), .btn(btn2),
        .waiting(waiting2), .led_on(led_on2), .done(done2), .timeout(timeout2),
        .false_start(fs2), .resp_valid(rv2), .resp_time(rt2),
        .winner(winner2), .winner_valid(wv2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_at(input int unsigned n);
        logic [15:0] v = 16'hACE1;
        for (int unsigned j = 0; j < n; j++)
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return v;
    endfunction

    // Per-round schedule in cycles from DELAY entry (k) or from TEST entry (t_c).
    int fs_k[NP], t_c[NP], hold_end[NP], plen[NP], rep[NP];

    task automatic clear_sched();
        for (int i = 0; i < NP; i++) begin
            fs_k[i] = -1; t_c[i] = -1; hold_end[i] = -1; plen[i] = 1; rep[i] = -1;
        end
    endtask

    function automatic bit btn_at(input int i, input int k);
        int tk;
        if (hold_end[i] >= 0 && k < hold_end[i]) return 1'b1;
        if (fs_k[i] == k) return 1'b1;
        if (t_c[i] >= 0) begin
            tk = DLY_CYC + t_c[i];
            if (k >= tk && k < tk + plen[i]) return 1'b1;
            if (rep[i] >= 0 && k == DLY_CYC + rep[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic begin_round();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < NP; i++) btn[i] = (hold_end[i] >= 0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_round(input string tag);
        int k, led_k, done_k, wbad, led_at_done;
        int nfs, maxfs, maxc, exp_led, exp_done;
        bit all_ok, exp_to, exp_wv, have;
        logic [NP-1:0]    exp_fs, exp_v;
        logic [NP*TW-1:0] exp_t;
        int exp_win, best;
        begin_round();
        k = 0; led_k = -1; done_k = -1; wbad = 0; led_at_done = 0;
        while (done_k < 0 && k < 150) begin
            @(negedge clk);
            if (led_on && led_k < 0) led_k = k;
            if (waiting) wbad++;
            if (done) begin
                done_k = k;
                led_at_done = int'(led_on);
            end else begin
                for (int i = 0; i < NP; i++) btn[i] = btn_at(i, k);
            end
            k++;
        end
        btn = '0;

        nfs = 0; maxfs = -1; maxc = -1; all_ok = 1'b1;
        exp_fs = '0; exp_v = '0; exp_t = '0;
        for (int i = 0; i < NP; i++) begin
            if (fs_k[i] >= 0) begin
                nfs++; exp_fs[i] = 1'b1;
                if (fs_k[i] > maxfs) maxfs = fs_k[i];
            end else if (t_c[i] >= 0 && t_c[i] < TEST_CYC) begin
                exp_v[i] = 1'b1;
                exp_t[i*TW +: TW] = TW'(t_c[i] / TICK);
                if (t_c[i] > maxc) maxc = t_c[i];
            end else begin
                all_ok = 1'b0;
            end
        end
        if (nfs == NP) begin
            exp_led = -1; exp_done = maxfs + 1; exp_to = 1'b0;
        end else if (all_ok) begin
            exp_led = DLY_CYC; exp_done = DLY_CYC + maxc + 1; exp_to = 1'b0;
        end else begin
            exp_led = DLY_CYC; exp_done = DLY_CYC + TEST_CYC; exp_to = 1'b1;
        end
        exp_win = 0; have = 1'b0; best = 0;
        for (int i = 0; i < NP; i++) begin
            if (exp_v[i] && (!have || t_c[i] / TICK < best)) begin
                have = 1'b1; best = t_c[i] / TICK; exp_win = i;
            end
        end
        exp_wv = have;

        check({tag, ".led_k"},   led_k, exp_led);
        check({tag, ".done_k"},  done_k, exp_done);
        check({tag, ".waiting"}, wbad, 0);
        check({tag, ".led_done"}, led_at_done, 0);
        check({tag, ".fs"},      false_start, exp_fs);
        check({tag, ".valid"},   resp_valid, exp_v);
        check({tag, ".time"},    resp_time, exp_t);
        check({tag, ".timeout"}, timeout, exp_to);
        check({tag, ".winner"},  winner, exp_win);
        check({tag, ".wvalid"},  winner_valid, exp_wv);
    endtask

    task automatic rand_delay_round(input int r);
        int unsigned n;
        int j, exp_cyc;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n = edge_cnt;
        start2 = 1'b0;
        exp_cyc = (2 + int'(lfsr_at(n) & 16'h0007)) * 2;
        j = 0;
        @(negedge clk);
        while (!led_on2 && j < 100) begin
            j++;
            @(negedge clk);
        end
        check($sformatf("rdly%0d.delay", r), j, exp_cyc);
        btn2 = 2'b11;
        @(negedge clk);
        btn2 = 2'b00;
        check($sformatf("rdly%0d.done", r), done2, 1);
        check($sformatf("rdly%0d.tie", r), {wv2, winner2, rv2, rt2}, {1'b1, 3'd0, 2'b11, 16'h0000});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.waiting", waiting, 1);
        check("rst.led_on",  led_on, 0);
        check("rst.done",    done, 0);
        check("rst.timeout", timeout, 0);
        check("rst.fs",      false_start, 0);
        check("rst.valid",   resp_valid, 0);
        check("rst.time",    resp_time, 0);
        check("rst.winner",  {winner_valid, winner}, 0);
        reset_n = 1'b1;

        clear_sched();
        t_c[2] = 20; t_c[0] = 28; t_c[1] = 36; t_c[3] = 36;
        run_round("order");

        clear_sched();
        fs_k[1] = 3; t_c[1] = 2; t_c[0] = 16; t_c[2] = 16; t_c[3] = 16;
        run_round("fs_one");

        clear_sched();
        fs_k[0] = 2; fs_k[1] = 5; fs_k[2] = 7; fs_k[3] = 9;
        run_round("fs_all");

        clear_sched();
        t_c[3] = 8;
        run_round("tmo");

        clear_sched();
        hold_end[0] = 14; t_c[0] = 6; t_c[1] = 10; t_c[2] = 12; t_c[3] = 12;
        run_round("held");

        for (int r = 0; r < 16; r++) begin
            clear_sched();
            for (int i = 0; i < NP; i++) begin
                int sel;
                sel = int'($urandom_range(0, 9));
                plen[i] = int'($urandom_range(1, 3));
                t_c[i] = int'($urandom_range(0, 70));
                if (t_c[i] == TEST_CYC - 1) t_c[i] = TEST_CYC - 2;
                if (sel < 2) begin
                    fs_k[i] = int'($urandom_range(0, DLY_CYC - 1));
                end else if (sel == 2) begin
                    t_c[i] = -1;
                end else if (sel == 3) begin
                    hold_end[i] = DLY_CYC + int'($urandom_range(0, 8));
                    t_c[i] = hold_end[i] - DLY_CYC + 1 + int'($urandom_range(0, 10));
                end
                if ($urandom_range(0, 1) == 1 && t_c[i] >= 0)
                    rep[i] = t_c[i] + plen[i] + 1 + int'($urandom_range(0, 5));
            end
            run_round($sformatf("rnd%0d", r));
        end

        clear_sched();
        t_c[2] = 1;
        begin_round();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) btn[i] = btn_at(i, k);
        end
        check("rst_mid.pre_valid", resp_valid, 4'b0100);
        check("rst_mid.pre_led", led_on, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid.waiting", waiting, 1);
        check("rst_mid.outs", {led_on, done, timeout, false_start, resp_valid, winner_valid, winner}, 0);
        check("rst_mid.time", resp_time, 0);
        btn = '0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            rand_delay_round(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
